oram_emit_arbiter: RTL and testbench

- Owns the single output-RAM write port (the `write` unit's start/ready handshake) and shares it between two requesters.
- Requester A is the translator's in-order ARM instruction stream. It is appended at a running emit pointer and decoupled by a small FIFO.
- Requester B is the branch back-patcher. It overwrites an already-emitted word at an explicit address.
- The block sits between the translator top-level (arm_inst/valid_write) and the write unit, and replaces the direct valid_write→start connection.

---
 rtl/oram_emit_arbiter_if.sv | 32 +++
 rtl/oram_emit_arbiter.sv | 132 +++++++++++++
 tb/tb_oram_emit_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oram_emit_arbiter_if.sv
// Bundle of requester, write-unit and status signals around the output-RAM emit arbiter.
// slave is the arbiter side; master is the environment (translator, patcher, write unit).
interface oram_emit_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              restart;
  logic              a_valid;
  logic [31:0]       a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_data;
  logic              b_ready;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] emit_ptr;
  logic              overflow;
  logic              patch_err;
  logic              busy;

  modport slave (
    input  restart, a_valid, a_data, b_valid, b_addr, b_data, wr_ready,
    output a_ready, b_ready, wr_start, wr_addr, wr_data, emit_ptr, overflow, patch_err, busy
  );

  modport master (
    output restart, a_valid, a_data, b_valid, b_addr, b_data, wr_ready,
    input  a_ready, b_ready, wr_start, wr_addr, wr_data, emit_ptr, overflow, patch_err, busy
  );
endinterface

// File: rtl/oram_emit_arbiter.sv
// Shares the single output-RAM write port between the translator stream (FIFO-buffered
// append at a running emit pointer) and the branch back-patcher (overwrite at an address).
module oram_emit_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic                clk,
  input logic                reset,
  oram_emit_arbiter_if.slave bus
);

  localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_emit_ptr, r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_overflow, r_patch_err, r_last_b;

  logic w_full, w_a_pend, w_slot, w_a_ready, w_push;
  logic w_grant_a, w_grant_b, w_b_bad;

  assign w_full    = (r_count == FULL_CNT);
  assign w_a_pend  = (r_count != '0);
  // A grant slot exists only in IDLE with an idle write unit and no restart this cycle.
  assign w_slot    = reset && (r_state == StIdle) && bus.wr_ready && !bus.restart;
  assign w_a_ready = reset && !w_full && !r_overflow && !bus.restart;
  assign w_push    = bus.a_valid && w_a_ready;
  assign w_grant_a = w_slot && w_a_pend && (!bus.b_valid || r_last_b);
  assign w_grant_b = w_slot && bus.b_valid && (!w_a_pend || !r_last_b);
  assign w_b_bad   = (bus.b_addr >= r_emit_ptr);

  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_grant_b;
  // A restart landing on the ISSUE cycle cancels the command before the unit ever sees it.
  assign bus.wr_start  = (r_state == StIssue) && !bus.restart;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.emit_ptr  = r_emit_ptr;
  assign bus.overflow  = r_overflow;
  assign bus.patch_err = r_patch_err;
  assign bus.busy      = (r_state != StIdle) || w_a_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:     if (w_grant_a || (w_grant_b && !w_b_bad)) w_state_nxt = StIssue;
      StIssue:    w_state_nxt = bus.restart ? StIdle : StWaitBusy;
      StWaitBusy: if (!bus.wr_ready) w_state_nxt = StWaitDone;
      StWaitDone: if (bus.wr_ready) w_state_nxt = StIdle;
      default:    w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.a_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_emit_ptr  <= BASE;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_overflow  <= 1'b0;
      r_patch_err <= 1'b0;
      r_last_b    <= 1'b1;
    end else if (bus.restart) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_emit_ptr  <= BASE;
      r_overflow  <= 1'b0;
      r_patch_err <= 1'b0;
      r_last_b    <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_grant_a) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_grant_a);

      if (w_grant_a) begin
        r_last_b  <= 1'b0;
        r_wr_addr <= r_emit_ptr;
        r_wr_data <= r_mem[r_rptr];
        // Last address: write it, then freeze the pointer and discard the queued words.
        if (r_emit_ptr == PTR_LAST) begin
          r_overflow <= 1'b1;
          r_wptr     <= '0;
          r_rptr     <= '0;
          r_count    <= '0;
        end else begin
          r_emit_ptr <= r_emit_ptr + ADDR_W'(1);
        end
      end

      if (w_grant_b) begin
        r_last_b <= 1'b1;
        if (w_b_bad) begin
          r_patch_err <= 1'b1;
        end else begin
          r_wr_addr <= bus.b_addr;
          r_wr_data <= bus.b_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_oram_emit_arbiter.sv
// Self-checking bench for oram_emit_arbiter: patch vector table plus directed sequences
// for streaming, backpressure, contention, async reset and pointer overflow.
module tb_oram_emit_arbiter;
  localparam int unsigned AW  = 10;
  localparam int unsigned AW2 = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oram_emit_arbiter_if #(.ADDR_W(AW))  ifc  ();
  oram_emit_arbiter_if #(.ADDR_W(AW2)) ifc2 ();

  oram_emit_arbiter #(.ADDR_W(AW), .DEPTH(4), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );
  oram_emit_arbiter #(.ADDR_W(AW2), .DEPTH(4), .BASE_ADDR(0)) u_dut2 (
    .clk(clk), .reset(reset), .bus(ifc2.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Write-unit models: wr_ready low for busy_cyc cycles after each wr_start.
  int              busy_cyc  = 2;
  bit              hold_busy = 1'b0;
  int              cnt;
  logic [AW-1:0]   log_addr[$];
  logic [31:0]     log_data[$];
  logic [31:0]     mem [1024];
  int              cnt2;
  logic [AW2-1:0]  log2_addr[$];
  logic [31:0]     log2_data[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifc.wr_ready <= 1'b1;
      cnt          <= 0;
    end else if (ifc.wr_start) begin
      ifc.wr_ready <= 1'b0;
      cnt          <= busy_cyc - 1;
      log_addr.push_back(ifc.wr_addr);
      log_data.push_back(ifc.wr_data);
      mem[ifc.wr_addr] <= ifc.wr_data;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end else begin
      ifc.wr_ready <= !hold_busy;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifc2.wr_ready <= 1'b1;
      cnt2          <= 0;
    end else if (ifc2.wr_start) begin
      ifc2.wr_ready <= 1'b0;
      cnt2          <= 1;
      log2_addr.push_back(ifc2.wr_addr);
      log2_data.push_back(ifc2.wr_data);
    end else if (cnt2 > 0) begin
      cnt2 <= cnt2 - 1;
    end else begin
      ifc2.wr_ready <= 1'b1;
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            wr;
    bit            err;
  } patch_vec_t;
  patch_vec_t pv [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    ifc.a_valid = 1'b1;
    ifc.a_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1 rdy = ifc.a_ready;
      @(negedge clk);
      ok = rdy;
    end
    ifc.a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [AW-1:0] a, input logic [31:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    ifc.b_valid = 1'b1;
    ifc.b_addr  = a;
    ifc.b_data  = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1 rdy = ifc.b_ready;
      @(negedge clk);
      ok = rdy;
    end
    ifc.b_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (ifc.busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit rdy;
    int idx;
    int first_drop;
    int n_before;
    logic [31:0] wa [3];

    pv[0] = '{10'd0,    32'hEA000001, 1'b1, 1'b0};
    pv[1] = '{10'd2,    32'hEA000002, 1'b1, 1'b0};
    pv[2] = '{10'd3,    32'hEA000003, 1'b0, 1'b1};
    pv[3] = '{10'd1023, 32'hEA000004, 1'b0, 1'b1};
    pv[4] = '{10'd1,    32'hEA000006, 1'b1, 1'b1};
    wa[0] = 32'hE3400011;
    wa[1] = 32'hE3400022;
    wa[2] = 32'hE52D0004;

    ifc.restart = 1'b0; ifc.a_valid = 1'b0; ifc.a_data = '0;
    ifc.b_valid = 1'b1; ifc.b_addr = '0;   ifc.b_data = '0;
    ifc2.restart = 1'b0; ifc2.a_valid = 1'b0; ifc2.a_data = '0;
    ifc2.b_valid = 1'b0; ifc2.b_addr = '0;   ifc2.b_data = '0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst wr_start",  32'(ifc.wr_start), 0);
    check("rst wr_addr",   32'(ifc.wr_addr), 0);
    check("rst wr_data",   ifc.wr_data, 0);
    check("rst emit_ptr",  32'(ifc.emit_ptr), 0);
    check("rst overflow",  32'(ifc.overflow), 0);
    check("rst patch_err", 32'(ifc.patch_err), 0);
    check("rst busy",      32'(ifc.busy), 0);
    check("rst a_ready",   32'(ifc.a_ready), 0);
    check("rst b_ready",   32'(ifc.b_ready), 0);
    ifc.b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("post-rst a_ready", 32'(ifc.a_ready), 1);
    @(negedge clk);

    // Single A stream
    for (int i = 0; i < 3; i++) begin
      push_a(wa[i], ok);
      check($sformatf("stream accept %0d", i), 32'(ok), 1);
    end
    wait_idle("stream idle");
    check("stream writes", 32'(log_addr.size()), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check($sformatf("stream addr %0d", i), 32'(log_addr[i]), 32'(i));
      check($sformatf("stream data %0d", i), log_data[i], wa[i]);
    end
    check("stream emit_ptr", 32'(ifc.emit_ptr), 3);

    // Patch vector table against emit_ptr=3; patch_err is sticky across vectors
    for (int k = 0; k < 5; k++) begin
      n_before = log_addr.size();
      send_b(pv[k].addr, pv[k].data, ok);
      check($sformatf("patch%0d accepted", k), 32'(ok), 1);
      wait_idle($sformatf("patch%0d idle", k));
      check($sformatf("patch%0d writes", k), 32'(log_addr.size() - n_before), 32'(pv[k].wr));
      if (pv[k].wr && log_addr.size() > n_before) begin
        check($sformatf("patch%0d addr", k), 32'(log_addr[n_before]), 32'(pv[k].addr));
        check($sformatf("patch%0d mem", k), mem[pv[k].addr], pv[k].data);
      end
      check($sformatf("patch%0d patch_err", k), 32'(ifc.patch_err), 32'(pv[k].err));
    end
    n_before = log_addr.size();
    push_a(32'hE1A00000, ok);
    wait_idle("post-patch A idle");
    check("post-patch A writes", 32'(log_addr.size() - n_before), 1);
    if (log_addr.size() > n_before) begin
      check("post-patch A addr", 32'(log_addr[n_before]), 3);
    end
    check("post-patch emit_ptr", 32'(ifc.emit_ptr), 4);

    ifc.restart = 1'b1;
    @(negedge clk);
    ifc.restart = 1'b0;
    check("restart emit_ptr",  32'(ifc.emit_ptr), 0);
    check("restart patch_err", 32'(ifc.patch_err), 0);

    // FIFO backpressure with a slow write unit
    busy_cyc = 5;
    log_addr.delete();
    log_data.delete();
    idx = 0;
    first_drop = -1;
    ifc.a_valid = 1'b1;
    for (int c = 0; c < 400 && idx < 8; c++) begin
      ifc.a_data = 32'h10000000 + idx;
      #1 rdy = ifc.a_ready;
      if (!rdy && first_drop < 0) first_drop = idx;
      @(negedge clk);
      if (rdy) idx++;
    end
    ifc.a_valid = 1'b0;
    check("bp accepts before stall", 32'(first_drop), 5);
    check("bp total accepts", 32'(idx), 8);
    wait_idle("bp idle");
    check("bp writes", 32'(log_addr.size()), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      check($sformatf("bp addr %0d", i), 32'(log_addr[i]), 32'(i));
      check($sformatf("bp data %0d", i), log_data[i], 32'h10000000 + i);
    end
    check("bp emit_ptr", 32'(ifc.emit_ptr), 8);

    // Contention: two A words queued and a patch pending at the same instant.
    // The patch targets address 0 so it is already emitted when B's turn comes.
    ifc.restart = 1'b1;
    @(negedge clk);
    ifc.restart = 1'b0;
    busy_cyc = 2;
    log_addr.delete();
    log_data.delete();
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    push_a(32'hA0000000, ok);
    push_a(32'hA0000001, ok);
    ifc.b_valid = 1'b1;
    ifc.b_addr  = 10'd0;
    ifc.b_data  = 32'hEA000005;
    #1 check("cont b_ready while unit busy", 32'(ifc.b_ready), 0);
    @(negedge clk);
    hold_busy = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      #1 rdy = ifc.b_ready;
      @(negedge clk);
      ok = rdy;
    end
    ifc.b_valid = 1'b0;
    check("cont b accepted", 32'(ok), 1);
    wait_idle("cont idle");
    check("cont writes", 32'(log_addr.size()), 3);
    if (log_addr.size() == 3) begin
      check("cont 1st addr", 32'(log_addr[0]), 0);
      check("cont 1st data", log_data[0], 32'hA0000000);
      check("cont 2nd addr", 32'(log_addr[1]), 0);
      check("cont 2nd data", log_data[1], 32'hEA000005);
      check("cont 3rd addr", 32'(log_addr[2]), 1);
      check("cont 3rd data", log_data[2], 32'hA0000001);
    end
    check("cont mem[0]", mem[0], 32'hEA000005);
    check("cont emit_ptr", 32'(ifc.emit_ptr), 2);

    // Async reset during WAIT_BUSY
    busy_cyc = 3;
    push_a(32'hCAFE0001, ok);
    for (int c = 0; c < 20 && !ifc.wr_start; c++) @(negedge clk);
    check("mid wr_start seen", 32'(ifc.wr_start), 1);
    check("mid wr_addr", 32'(ifc.wr_addr), 2);
    @(negedge clk);
    check("mid unit busy", 32'(ifc.wr_ready), 0);
    #2 reset = 1'b0;
    #1;
    check("arst wr_start", 32'(ifc.wr_start), 0);
    check("arst wr_addr",  32'(ifc.wr_addr), 0);
    check("arst wr_data",  ifc.wr_data, 0);
    check("arst emit_ptr", 32'(ifc.emit_ptr), 0);
    check("arst busy",     32'(ifc.busy), 0);
    check("arst a_ready",  32'(ifc.a_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    push_a(32'hCAFE0002, ok);
    wait_idle("arst resume idle");
    check("arst resume writes", 32'(log_addr.size()), 1);
    if (log_addr.size() == 1) begin
      check("arst resume addr", 32'(log_addr[0]), 0);
      check("arst resume data", log_data[0], 32'hCAFE0002);
    end

    // Overflow on the 2-bit-address instance
    idx = 0;
    ifc2.a_valid = 1'b1;
    for (int c = 0; c < 100 && idx < 5; c++) begin
      ifc2.a_data = 32'h50000000 + idx;
      #1 rdy = ifc2.a_ready;
      @(negedge clk);
      if (rdy) idx++;
    end
    ifc2.a_valid = 1'b0;
    check("ovf accepts", 32'(idx), 5);
    for (int c = 0; c < 200 && ifc2.busy; c++) @(negedge clk);
    check("ovf idle", 32'(ifc2.busy), 0);
    check("ovf writes", 32'(log2_addr.size()), 4);
    for (int i = 0; i < 4 && i < log2_addr.size(); i++) begin
      check($sformatf("ovf addr %0d", i), 32'(log2_addr[i]), 32'(i));
      check($sformatf("ovf data %0d", i), log2_data[i], 32'h50000000 + i);
    end
    check("ovf flag",     32'(ifc2.overflow), 1);
    check("ovf emit_ptr", 32'(ifc2.emit_ptr), 3);
    check("ovf a_ready",  32'(ifc2.a_ready), 0);
    ifc2.restart = 1'b1;
    @(negedge clk);
    ifc2.restart = 1'b0;
    #1;
    check("ovf restart emit_ptr", 32'(ifc2.emit_ptr), 0);
    check("ovf restart flag",     32'(ifc2.overflow), 0);
    check("ovf restart a_ready",  32'(ifc2.a_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
